// File: rtl/game_seq_pkg.sv
// Shared encodings and widths for the game screen sequencer.
// Build option: GAME_SEQ_FADE_EN enables the per-state fade-in (see screen_fader).
package game_seq_pkg;

    localparam int STATE_W = 3;
    localparam int LEVEL_W = 4;
    localparam int LIVES_W = 3;

    localparam logic [STATE_W-1:0] TITLE       = 3'd0;
    localparam logic [STATE_W-1:0] PLAYING     = 3'd1;
    localparam logic [STATE_W-1:0] LEVEL_CLEAR = 3'd2;
    localparam logic [STATE_W-1:0] WIN         = 3'd3;
    localparam logic [STATE_W-1:0] GAME_OVER   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_TITLE       = TITLE,
        S_PLAYING     = PLAYING,
        S_LEVEL_CLEAR = LEVEL_CLEAR,
        S_WIN         = WIN,
        S_GAME_OVER   = GAME_OVER
    } state_e;

    // Lives never wrap below zero.
    function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] v);
        return (v == '0) ? v : v - LIVES_W'(1);
    endfunction

endpackage

// File: rtl/game_screen_sequencer_if.sv
// Video timing, game events, screen sources and sequencer outputs bundled as one bus.
// The sequencer is the slave; whoever drives timing/events/pixels is the master.
interface game_screen_sequencer_if #(parameter int RGB_W = 12);
    import game_seq_pkg::*;

    logic               p_tick;
    logic               frame_tick;
    logic               video_on;
    logic               game_start;
    logic               pause;
    logic               wave_clear;
    logic               player_hit;
    logic [RGB_W-1:0]   title_rgb;
    logic [RGB_W-1:0]   game_rgb;
    logic [RGB_W-1:0]   clear_rgb;
    logic [RGB_W-1:0]   win_rgb;
    logic [RGB_W-1:0]   over_rgb;
    logic [RGB_W-1:0]   rgb;
    logic [STATE_W-1:0] state;
    logic [LEVEL_W-1:0] level;
    logic [LIVES_W-1:0] lives;
    logic               freeze;
    logic               game_reset;

    modport master (
        output p_tick, frame_tick, video_on, game_start, pause, wave_clear, player_hit,
        output title_rgb, game_rgb, clear_rgb, win_rgb, over_rgb,
        input  rgb, state, level, lives, freeze, game_reset
    );

    modport slave (
        input  p_tick, frame_tick, video_on, game_start, pause, wave_clear, player_hit,
        input  title_rgb, game_rgb, clear_rgb, win_rgb, over_rgb,
        output rgb, state, level, lives, freeze, game_reset
    );

endinterface

// File: rtl/screen_fader.sv
// Fade-in for the composited screen: each R/G/B slice is shifted right by a 2-bit step
// that reloads to 3 on every state change and steps down once per 8 unpaused frames.
module screen_fader
    import game_seq_pkg::*;
#(
    parameter int RGB_W = 12
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               pause,
    input  logic [STATE_W-1:0] state,
    input  logic [RGB_W-1:0]   pix_in,
    output logic [RGB_W-1:0]   pix_out
);

    localparam int SLICE_W = RGB_W / 3;

    logic [STATE_W-1:0] last_state;
    logic [1:0]         step_q;
    logic [2:0]         div_q;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            last_state <= TITLE;
            step_q     <= 2'd0;
            div_q      <= 3'd7;
        end else begin
            last_state <= state;
            if (state != last_state) begin
                step_q <= 2'd3;
                div_q  <= 3'd7;
            end else if (frame_tick && !pause) begin
                if (div_q == 3'd0) begin
                    div_q <= 3'd7;
                    if (step_q != 2'd0)
                        step_q <= step_q - 2'd1;
                end else begin
                    div_q <= div_q - 3'd1;
                end
            end
        end
    end

    always_comb begin
        pix_out = '0;
        for (int i = 0; i < 3; i++)
            pix_out[i*SLICE_W +: SLICE_W] = pix_in[i*SLICE_W +: SLICE_W] >> step_q;
    end

endmodule

// File: rtl/game_screen_sequencer.sv
// Frame-synchronous game-flow FSM (levels, lives, clear banner) and registered, blanked
// screen compositor. Optional GAME_SEQ_FADE_EN inserts screen_fader before blanking.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   TITLE       | title screen, waits for game_start at a frame boundary
//   PLAYING     | gameplay; hit/clear events latched, evaluated per frame
//   LEVEL_CLEAR | banner shown for CLEAR_FRAMES unpaused frames
//   WIN         | all levels cleared, held until game_start drops
//   GAME_OVER   | lives exhausted, held until game_start drops
module game_screen_sequencer
    import game_seq_pkg::*;
#(
    parameter int RGB_W        = 12,
    parameter int LEVELS       = 3,
    parameter int LIVES        = 3,
    parameter int CLEAR_FRAMES = 120
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    game_screen_sequencer_if.slave bus
);

    state_e             state_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LIVES_W-1:0] lives_q;
    logic [7:0]         timer_q;
    logic               hit_flag;
    logic               clear_flag;
    logic               game_reset_q;
    logic [RGB_W-1:0]   rgb_q;

    logic               hit_now;
    logic               clear_now;
    logic [LIVES_W-1:0] lives_after_hit;
    logic [RGB_W-1:0]   mux_rgb;
    logic [RGB_W-1:0]   shown_rgb;

    // A pulse landing on the frame_tick cycle itself still counts for this frame.
    always_comb begin
        hit_now         = hit_flag | bus.player_hit;
        clear_now       = clear_flag | bus.wave_clear;
        lives_after_hit = hit_now ? lives_dec(lives_q) : lives_q;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q      <= S_TITLE;
            level_q      <= '0;
            lives_q      <= LIVES_W'(LIVES);
            timer_q      <= '0;
            hit_flag     <= 1'b0;
            clear_flag   <= 1'b0;
            game_reset_q <= 1'b0;
        end else begin
            game_reset_q <= 1'b0;
            if (state_q == S_PLAYING) begin
                if (bus.player_hit) hit_flag   <= 1'b1;
                if (bus.wave_clear) clear_flag <= 1'b1;
            end
            if (bus.frame_tick) begin
                hit_flag   <= 1'b0;
                clear_flag <= 1'b0;
                case (state_q)
                    S_TITLE: begin
                        if (bus.game_start) begin
                            state_q      <= S_PLAYING;
                            level_q      <= '0;
                            lives_q      <= LIVES_W'(LIVES);
                            game_reset_q <= 1'b1;
                        end
                    end
                    S_PLAYING: begin
                        if (!bus.game_start) begin
                            state_q <= S_TITLE;
                        end else begin
                            lives_q <= lives_after_hit;
                            if (hit_now && lives_after_hit == '0) begin
                                state_q <= S_GAME_OVER;
                            end else if (clear_now) begin
                                state_q <= S_LEVEL_CLEAR;
                                timer_q <= 8'(CLEAR_FRAMES - 1);
                            end
                        end
                    end
                    S_LEVEL_CLEAR: begin
                        if (!bus.game_start) begin
                            state_q <= S_TITLE;
                        end else if (!bus.pause) begin
                            if (timer_q != 8'd0) begin
                                timer_q <= timer_q - 8'd1;
                            end else if (level_q == LEVEL_W'(LEVELS - 1)) begin
                                state_q <= S_WIN;
                            end else begin
                                level_q      <= level_q + LEVEL_W'(1);
                                state_q      <= S_PLAYING;
                                game_reset_q <= 1'b1;
                            end
                        end
                    end
                    S_WIN, S_GAME_OVER: begin
                        if (!bus.game_start)
                            state_q <= S_TITLE;
                    end
                    default: state_q <= S_TITLE;
                endcase
            end
        end
    end

    always_comb begin
        mux_rgb = '0;
        case (state_q)
            S_TITLE:       mux_rgb = bus.title_rgb;
            S_PLAYING:     mux_rgb = bus.game_rgb;
            S_LEVEL_CLEAR: mux_rgb = bus.clear_rgb;
            S_WIN:         mux_rgb = bus.win_rgb;
            S_GAME_OVER:   mux_rgb = bus.over_rgb;
            default:       mux_rgb = '0;
        endcase
    end

`ifdef GAME_SEQ_FADE_EN
    screen_fader #(.RGB_W(RGB_W)) u_screen_fader (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .frame_tick (bus.frame_tick),
        .pause      (bus.pause),
        .state      (state_q),
        .pix_in     (mux_rgb),
        .pix_out    (shown_rgb)
    );
`else
    assign shown_rgb = mux_rgb;
`endif

    always_ff @(posedge clk_100MHz) begin
        if (reset)
            rgb_q <= '0;
        else if (bus.p_tick)
            rgb_q <= bus.video_on ? shown_rgb : '0;
    end

    assign bus.rgb        = rgb_q;
    assign bus.state      = state_q;
    assign bus.level      = level_q;
    assign bus.lives      = lives_q;
    assign bus.game_reset = game_reset_q;
    assign bus.freeze     = (state_q != S_PLAYING) | bus.pause | ~bus.game_start;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Directed bench for game_screen_sequencer with LEVELS=3, LIVES=3, CLEAR_FRAMES=4.
module tb_game_screen_sequencer;

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   gr_cnt       = 0;
    int   g0;

    game_screen_sequencer_if #(.RGB_W(12)) bus ();

    game_screen_sequencer #(
        .RGB_W(12), .LEVELS(3), .LIVES(3), .CLEAR_FRAMES(4)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(negedge clk_100MHz) if (bus.game_reset === 1'b1) gr_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic tick_frame();
        @(negedge clk_100MHz) bus.frame_tick = 1'b1;
        @(negedge clk_100MHz) bus.frame_tick = 1'b0;
    endtask

    task automatic pulse_hit();
        @(negedge clk_100MHz) bus.player_hit = 1'b1;
        @(negedge clk_100MHz) bus.player_hit = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk_100MHz) bus.wave_clear = 1'b1;
        @(negedge clk_100MHz) bus.wave_clear = 1'b0;
    endtask

    task automatic pulse_both();
        @(negedge clk_100MHz) begin bus.wave_clear = 1'b1; bus.player_hit = 1'b1; end
        @(negedge clk_100MHz) begin bus.wave_clear = 1'b0; bus.player_hit = 1'b0; end
    endtask

    task automatic pulse_pix();
        @(negedge clk_100MHz) bus.p_tick = 1'b1;
        @(negedge clk_100MHz) bus.p_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        tests_run++; if (bus.state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        tests_run++; if (bus.level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        tests_run++; if (bus.lives !== 3'd3) begin tests_failed++; $display("FAIL reset_lives: got %0d want 3", bus.lives); end
        tests_run++; if (bus.rgb !== 12'h000) begin tests_failed++; $display("FAIL reset_rgb: got %h want 000", bus.rgb); end
        tests_run++; if (bus.game_reset !== 1'b0) begin tests_failed++; $display("FAIL reset_game_reset: got %b want 0", bus.game_reset); end
        tests_run++; if (bus.freeze !== 1'b1) begin tests_failed++; $display("FAIL reset_freeze: got %b want 1", bus.freeze); end
    endtask

    task automatic test_start();
        bus.game_start = 1'b1;
        g0 = gr_cnt;
        tick_frame();
        tests_run++; if (bus.state !== 3'd1) begin tests_failed++; $display("FAIL start_state: got %0d want 1", bus.state); end
        tests_run++; if (bus.level !== 4'd0) begin tests_failed++; $display("FAIL start_level: got %0d want 0", bus.level); end
        tests_run++; if (bus.lives !== 3'd3) begin tests_failed++; $display("FAIL start_lives: got %0d want 3", bus.lives); end
        tests_run++; if (bus.game_reset !== 1'b1) begin tests_failed++; $display("FAIL start_game_reset_hi: got %b want 1", bus.game_reset); end
        cyc(1);
        tests_run++; if (bus.game_reset !== 1'b0) begin tests_failed++; $display("FAIL start_game_reset_lo: got %b want 0", bus.game_reset); end
        tests_run++; if (gr_cnt - g0 !== 1) begin tests_failed++; $display("FAIL start_game_reset_width: got %0d want 1", gr_cnt - g0); end
        tests_run++; if (bus.freeze !== 1'b0) begin tests_failed++; $display("FAIL start_freeze: got %b want 0", bus.freeze); end
`ifndef GAME_SEQ_FADE_EN
        bus.game_rgb = 12'hABC;
        bus.video_on = 1'b1;
        cyc(1);
        tests_run++; if (bus.rgb !== 12'h000) begin tests_failed++; $display("FAIL rgb_no_ptick: got %h want 000", bus.rgb); end
        pulse_pix();
        tests_run++; if (bus.rgb !== 12'hABC) begin tests_failed++; $display("FAIL rgb_game: got %h want ABC", bus.rgb); end
        bus.video_on = 1'b0;
        pulse_pix();
        tests_run++; if (bus.rgb !== 12'h000) begin tests_failed++; $display("FAIL rgb_blank: got %h want 000", bus.rgb); end
`endif
        bus.pause = 1'b1;
        cyc(1);
        tests_run++; if (bus.freeze !== 1'b1) begin tests_failed++; $display("FAIL pause_freeze: got %b want 1", bus.freeze); end
        bus.pause = 1'b0;
    endtask

    task automatic test_hits();
        g0 = gr_cnt;
        pulse_hit(); tick_frame();
        tests_run++; if (bus.lives !== 3'd2) begin tests_failed++; $display("FAIL hit1_lives: got %0d want 2", bus.lives); end
        tests_run++; if (bus.state !== 3'd1) begin tests_failed++; $display("FAIL hit1_state: got %0d want 1", bus.state); end
        pulse_hit(); tick_frame();
        tests_run++; if (bus.lives !== 3'd1) begin tests_failed++; $display("FAIL hit2_lives: got %0d want 1", bus.lives); end
        pulse_hit(); cyc(3);
        tests_run++; if (bus.state !== 3'd1 || bus.lives !== 3'd1) begin tests_failed++; $display("FAIL hit3_midframe: got state %0d lives %0d want 1 1", bus.state, bus.lives); end
        tick_frame();
        tests_run++; if (bus.lives !== 3'd0) begin tests_failed++; $display("FAIL hit3_lives: got %0d want 0", bus.lives); end
        tests_run++; if (bus.state !== 3'd4) begin tests_failed++; $display("FAIL hit3_state: got %0d want 4", bus.state); end
        cyc(1);
        tests_run++; if (gr_cnt - g0 !== 0) begin tests_failed++; $display("FAIL hits_no_game_reset: got %0d want 0", gr_cnt - g0); end
        tick_frame();
        tests_run++; if (bus.state !== 3'd4) begin tests_failed++; $display("FAIL over_hold: got %0d want 4", bus.state); end
        bus.game_start = 1'b0;
        cyc(3);
        tests_run++; if (bus.state !== 3'd4) begin tests_failed++; $display("FAIL over_wait_frame: got %0d want 4", bus.state); end
        tick_frame();
        tests_run++; if (bus.state !== 3'd0) begin tests_failed++; $display("FAIL over_to_title: got %0d want 0", bus.state); end
        tests_run++; if (bus.lives !== 3'd0) begin tests_failed++; $display("FAIL title_lives_held: got %0d want 0", bus.lives); end
    endtask

    task automatic test_drop_in_title();
        pulse_hit(); pulse_clear();
        bus.game_start = 1'b1;
        tick_frame();
        tests_run++; if (bus.lives !== 3'd3 || bus.state !== 3'd1) begin tests_failed++; $display("FAIL restart: got state %0d lives %0d want 1 3", bus.state, bus.lives); end
        tick_frame();
        tests_run++; if (bus.lives !== 3'd3 || bus.state !== 3'd1) begin tests_failed++; $display("FAIL title_events_dropped: got state %0d lives %0d want 1 3", bus.state, bus.lives); end
    endtask

    task automatic test_banner();
        pulse_clear(); cyc(3);
        tests_run++; if (bus.state !== 3'd1) begin tests_failed++; $display("FAIL clear_midframe: got %0d want 1", bus.state); end
        tick_frame();
        tests_run++; if (bus.state !== 3'd2) begin tests_failed++; $display("FAIL banner_enter: got %0d want 2", bus.state); end
        for (int i = 1; i <= 3; i++) begin
            tick_frame();
            tests_run++; if (bus.state !== 3'd2) begin tests_failed++; $display("FAIL banner_frame%0d: got %0d want 2", i, bus.state); end
        end
        g0 = gr_cnt;
        tick_frame();
        tests_run++; if (bus.state !== 3'd1 || bus.level !== 4'd1) begin tests_failed++; $display("FAIL banner_exit: got state %0d level %0d want 1 1", bus.state, bus.level); end
        cyc(1);
        tests_run++; if (gr_cnt - g0 !== 1) begin tests_failed++; $display("FAIL banner_game_reset: got %0d want 1", gr_cnt - g0); end
        pulse_clear(); tick_frame();
        bus.pause = 1'b1;
        tick_frame(); tick_frame();
        tests_run++; if (bus.state !== 3'd2 || bus.freeze !== 1'b1) begin tests_failed++; $display("FAIL banner_paused: got state %0d freeze %b want 2 1", bus.state, bus.freeze); end
        bus.pause = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick_frame();
            tests_run++; if (bus.state !== 3'd2) begin tests_failed++; $display("FAIL pause_banner_frame%0d: got %0d want 2", i, bus.state); end
        end
        tick_frame();
        tests_run++; if (bus.state !== 3'd1 || bus.level !== 4'd2) begin tests_failed++; $display("FAIL pause_banner_exit: got state %0d level %0d want 1 2", bus.state, bus.level); end
    endtask

    task automatic test_win();
        pulse_clear(); tick_frame();
`ifndef GAME_SEQ_FADE_EN
        bus.clear_rgb = 12'h5A5;
        bus.video_on  = 1'b1;
        pulse_pix();
        tests_run++; if (bus.rgb !== 12'h5A5) begin tests_failed++; $display("FAIL rgb_clear: got %h want 5A5", bus.rgb); end
`endif
        repeat (3) tick_frame();
        tick_frame();
        tests_run++; if (bus.state !== 3'd3 || bus.level !== 4'd2) begin tests_failed++; $display("FAIL win_enter: got state %0d level %0d want 3 2", bus.state, bus.level); end
        bus.game_start = 1'b0;
        cyc(4);
        tests_run++; if (bus.state !== 3'd3) begin tests_failed++; $display("FAIL win_wait_frame: got %0d want 3", bus.state); end
        tick_frame();
        tests_run++; if (bus.state !== 3'd0 || bus.level !== 4'd2) begin tests_failed++; $display("FAIL win_to_title: got state %0d level %0d want 0 2", bus.state, bus.level); end
    endtask

    task automatic test_same_frame();
        bus.game_start = 1'b1;
        tick_frame();
        pulse_both(); tick_frame();
        tests_run++; if (bus.state !== 3'd2 || bus.lives !== 3'd2 || bus.level !== 4'd0) begin tests_failed++; $display("FAIL both_nonfatal: got state %0d lives %0d level %0d want 2 2 0", bus.state, bus.lives, bus.level); end
        repeat (4) tick_frame();
        pulse_hit(); tick_frame();
        tests_run++; if (bus.state !== 3'd1 || bus.lives !== 3'd1 || bus.level !== 4'd1) begin tests_failed++; $display("FAIL both_setup: got state %0d lives %0d level %0d want 1 1 1", bus.state, bus.lives, bus.level); end
        pulse_both(); tick_frame();
        tests_run++; if (bus.state !== 3'd4 || bus.lives !== 3'd0 || bus.level !== 4'd1) begin tests_failed++; $display("FAIL both_fatal: got state %0d lives %0d level %0d want 4 0 1", bus.state, bus.lives, bus.level); end
    endtask

    task automatic test_abort_and_reset();
        bus.game_start = 1'b0; tick_frame();
        bus.game_start = 1'b1; tick_frame();
        pulse_clear(); tick_frame();
        bus.game_start = 1'b0; tick_frame();
        tests_run++; if (bus.state !== 3'd0) begin tests_failed++; $display("FAIL banner_abort: got %0d want 0", bus.state); end
        bus.game_start = 1'b1; tick_frame();
        pulse_hit(); tick_frame();
        pulse_clear(); tick_frame();
        bus.clear_rgb = 12'hFFF; bus.video_on = 1'b1; bus.p_tick = 1'b1;
        cyc(2);
        tests_run++; if (bus.state !== 3'd2 || bus.rgb === 12'h000) begin tests_failed++; $display("FAIL pre_reset_banner: got state %0d rgb %h want 2 nonzero", bus.state, bus.rgb); end
        reset = 1'b1;
        cyc(1);
        tests_run++; if (bus.state !== 3'd0 || bus.level !== 4'd0 || bus.lives !== 3'd3) begin tests_failed++; $display("FAIL midbanner_reset_ctr: got state %0d level %0d lives %0d want 0 0 3", bus.state, bus.level, bus.lives); end
        tests_run++; if (bus.rgb !== 12'h000 || bus.game_reset !== 1'b0) begin tests_failed++; $display("FAIL midbanner_reset_out: got rgb %h game_reset %b want 000 0", bus.rgb, bus.game_reset); end
        reset = 1'b0; bus.p_tick = 1'b0; bus.video_on = 1'b0;
        tick_frame();
        pulse_hit(); pulse_clear();
        reset = 1'b1; cyc(1); reset = 1'b0;
        tick_frame(); tick_frame();
        tests_run++; if (bus.state !== 3'd1 || bus.lives !== 3'd3) begin tests_failed++; $display("FAIL flags_lost_on_reset: got state %0d lives %0d want 1 3", bus.state, bus.lives); end
    endtask

`ifdef GAME_SEQ_FADE_EN
    task automatic test_fade();
        logic [11:0] exp_fade [3];
        exp_fade[0] = 12'h333; exp_fade[1] = 12'h777; exp_fade[2] = 12'hFFF;
        reset = 1'b1; bus.game_start = 1'b0; cyc(2); reset = 1'b0;
        bus.game_rgb = 12'hFFF; bus.video_on = 1'b1; bus.p_tick = 1'b1;
        bus.game_start = 1'b1;
        tick_frame(); cyc(2);
        tests_run++; if (bus.rgb !== 12'h111) begin tests_failed++; $display("FAIL fade_step3: got %h want 111", bus.rgb); end
        for (int i = 0; i < 3; i++) begin
            repeat (8) tick_frame();
            cyc(1);
            tests_run++; if (bus.rgb !== exp_fade[i]) begin tests_failed++; $display("FAIL fade_step%0d: got %h want %h", 2 - i, bus.rgb, exp_fade[i]); end
        end
        bus.p_tick = 1'b0;
    endtask
`endif

    initial begin
        bus.p_tick = 1'b0; bus.frame_tick = 1'b0; bus.video_on = 1'b0;
        bus.game_start = 1'b0; bus.pause = 1'b0; bus.wave_clear = 1'b0; bus.player_hit = 1'b0;
        bus.title_rgb = 12'h123; bus.game_rgb = 12'h000; bus.clear_rgb = 12'h000;
        bus.win_rgb = 12'h456; bus.over_rgb = 12'h789;
        test_reset();
        test_start();
        test_hits();
        test_drop_in_title();
        test_banner();
        test_win();
        test_same_frame();
        test_abort_and_reset();
`ifdef GAME_SEQ_FADE_EN
        test_fade();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
